// File: rtl/mag_pkg.sv
// ---------------------------------------------------------------------------
// mag_pkg : shared types and helpers for the bit-serial magnitude comparator
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mag_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REL_EQ = 2'd0,
    REL_GT = 2'd1,
    REL_LT = 2'd2
  } rel_t;

  // Returns {eq, isG, isS}; exactly one bit is set for any legal relation.
  function automatic logic [2:0] rel_to_flags(input rel_t r);
    logic [2:0] f;
    case (r)
      REL_GT:  f = 3'b010;
      REL_LT:  f = 3'b001;
      default: f = 3'b100;
    endcase
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_cmp_cell.sv
// ---------------------------------------------------------------------------
// bit_cmp_cell : combinational single-bit compare (a > b, a < b)
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bit_cmp_cell (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic lt
);

  assign gt = a & ~b;
  assign lt = ~a & b;

endmodule

`default_nettype wire

// File: rtl/serial_mag_comparator.sv
// ---------------------------------------------------------------------------
// serial_mag_comparator : bit-serial A/B magnitude compare with start/valid
// handshake; eq/isG/isS registered and held until the next completion.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_mag_comparator
  import mag_pkg::*;
#(
  parameter int W         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic eq,
  output logic isG,
  output logic isS
);

  localparam int             CW     = $clog2(W + 1);
  localparam logic [CW-1:0]  c_LAST = CW'(W - 1);

  state_t        r_state;
  rel_t          r_rel;
  logic [CW-1:0] r_cnt;
  logic          r_eq;
  logic          r_isG;
  logic          r_isS;

  logic          w_gt;
  logic          w_lt;
  rel_t          w_next_rel;
  logic          w_last;

  bit_cmp_cell u_cell (
    .a  (a_bit),
    .b  (b_bit),
    .gt (w_gt),
    .lt (w_lt)
  );

  assign w_last = (r_cnt == c_LAST);

  // MSB-first: the first differing bit decides and freezes the relation.
  // LSB-first: each differing bit overwrites, so the most significant wins.
  generate
    if (MSB_FIRST) begin : g_msb_first
      always_comb begin
        w_next_rel = r_rel;
        if ((r_rel == REL_EQ) && (w_gt || w_lt))
          w_next_rel = w_gt ? REL_GT : REL_LT;
      end
    end else begin : g_lsb_first
      always_comb begin
        w_next_rel = r_rel;
        if (w_gt || w_lt)
          w_next_rel = w_gt ? REL_GT : REL_LT;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rel   <= REL_EQ;
      r_cnt   <= '0;
      r_eq    <= 1'b0;
      r_isG   <= 1'b0;
      r_isS   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= SHIFT;
            r_cnt   <= '0;
            r_rel   <= REL_EQ;
          end
        end
        SHIFT: begin
          if (bit_valid) begin
            r_rel <= w_next_rel;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_state                <= DONE;
              {r_eq, r_isG, r_isS}   <= rel_to_flags(w_next_rel);
            end
          end
        end
        DONE: begin
          if (start) begin
            r_state <= SHIFT;
            r_cnt   <= '0;
            r_rel   <= REL_EQ;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);
  assign eq   = r_eq;
  assign isG  = r_isG;
  assign isS  = r_isS;

endmodule

`default_nettype wire

// File: tb/tb_serial_mag_comparator.sv
// ---------------------------------------------------------------------------
// tb_serial_mag_comparator : scoreboard bench driving an MSB-first and an
// LSB-first instance from one shared serial stimulus stream.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_mag_comparator;

  logic clk = 1'b0;
  logic rst, start, bit_valid, a_bit, b_bit;
  logic busy_m, done_m, eq_m, isG_m, isS_m;
  logic busy_l, done_l, eq_l, isG_l, isS_l;

  logic [2:0] q_m[$];
  logic [2:0] q_l[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_mag_comparator #(.W(4), .MSB_FIRST(1'b1)) u_dut_m (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
    .a_bit(a_bit), .b_bit(b_bit), .busy(busy_m), .done(done_m),
    .eq(eq_m), .isG(isG_m), .isS(isS_m)
  );

  serial_mag_comparator #(.W(4), .MSB_FIRST(1'b0)) u_dut_l (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
    .a_bit(a_bit), .b_bit(b_bit), .busy(busy_l), .done(done_l),
    .eq(eq_l), .isG(isG_l), .isS(isS_l)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference relation as {eq, isG, isS} from plain unsigned compare.
  function automatic logic [2:0] ref_rel(input logic [3:0] a, input logic [3:0] b);
    if (a == b)     return 3'b100;
    else if (a > b) return 3'b010;
    else            return 3'b001;
  endfunction

  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (done_m) begin
        if (q_m.size() == 0) check("m_unexpected_done", 32'd1, 32'd0);
        else check("m_flags", {29'd0, eq_m, isG_m, isS_m}, {29'd0, q_m.pop_front()});
      end
      if (done_l) begin
        if (q_l.size() == 0) check("l_unexpected_done", 32'd1, 32'd0);
        else check("l_flags", {29'd0, eq_l, isG_l, isS_l}, {29'd0, q_l.pop_front()});
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", {31'd0, busy_m}, 32'd1);
  endtask

  // Sends nbits bit pairs of a/b; lsb_order picks transmission order.
  // sa/sb collect the sent stream with the first bit as MSB, which is the
  // value the MSB-first instance sees; the LSB-first one sees it reversed.
  task automatic send_bits(input logic [3:0] a, input logic [3:0] b, input bit lsb_order,
                           input int gap, input int nbits, input bit chain);
    logic [3:0] sa, sb;
    int idx;
    sa = '0;
    sb = '0;
    for (int i = 0; i < nbits; i++) begin
      idx       = lsb_order ? i : 3 - i;
      a_bit     = a[idx];
      b_bit     = b[idx];
      bit_valid = 1'b1;
      sa[3-i]   = a[idx];
      sb[3-i]   = b[idx];
      if (i == 3) begin
        q_m.push_back(ref_rel(sa, sb));
        q_l.push_back(ref_rel(rev4(sa), rev4(sb)));
      end
      @(posedge clk); #1;
      bit_valid = 1'b0;
      a_bit     = 1'b0;
      b_bit     = 1'b0;
      if (i != nbits - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
          check("busy_in_gap", {31'd0, busy_m}, 32'd1);
        end
      end
    end
    if (chain) start = 1'b1;
  endtask

  initial begin
    int budget;
    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_m", {27'd0, busy_m, done_m, eq_m, isG_m, isS_m}, 32'd0);
    check("reset_l", {27'd0, busy_l, done_l, eq_l, isG_l, isS_l}, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("idle_hold", {27'd0, busy_m, done_m, eq_m, isG_m, isS_m}, 32'd0);
    end

    // A < B, MSB-first, no stalls: done is the 5th cycle after start
    do_start();
    send_bits(4'b0111, 4'b1000, 1'b0, 0, 4, 1'b0);
    check("done_latency", {30'd0, done_m, busy_m}, 32'b10);
    @(posedge clk); #1;
    check("held_in_idle", {27'd0, busy_m, done_m, eq_m, isG_m, isS_m}, 32'b00001);

    // Equal operands with 2-cycle stalls between bits
    do_start();
    send_bits(4'b0100, 4'b0100, 1'b0, 2, 4, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // LSB-first transmission cases
    do_start();
    send_bits(4'b0111, 4'b0010, 1'b1, 0, 4, 1'b0);
    @(posedge clk); #1;
    do_start();
    send_bits(4'b1101, 4'b1111, 1'b1, 1, 4, 1'b0);
    @(posedge clk); #1;

    // Back-to-back: start held during DONE, no IDLE gap
    do_start();
    send_bits(4'b0001, 4'b0000, 1'b0, 0, 4, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_no_idle", {31'd0, busy_m}, 32'd1);
    check("b2b_held", {29'd0, eq_m, isG_m, isS_m}, 32'b010);
    send_bits(4'b0000, 4'b0000, 1'b0, 0, 4, 1'b0);
    @(posedge clk); #1;

    // Abort after 2 bits, then a fresh comparison
    do_start();
    send_bits(4'b1111, 4'b0000, 1'b0, 0, 2, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_m", {27'd0, busy_m, done_m, eq_m, isG_m, isS_m}, 32'd0);
    check("abort_l", {27'd0, busy_l, done_l, eq_l, isG_l, isS_l}, 32'd0);
    do_start();
    send_bits(4'b0111, 4'b0010, 1'b0, 0, 4, 1'b0);

    budget = 20;
    while ((q_m.size() != 0 || q_l.size() != 0) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("drain_m", q_m.size(), 32'd0);
    check("drain_l", q_l.size(), 32'd0);
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
